// File: rtl/cond_branch_unit_pkg.sv
// Shared parameters for the branch unit: datapath widths, flag bit positions,
// condition codes, FSM states and the ALU opcode set that produces the flags.
package cond_branch_unit_pkg;

    localparam int ALUWIDTH = 16;
    localparam int NUMFLAGS = 4;
    localparam int CONDSIZE = 4;

    // Flag vector layout is {C V Z N}, carry in the MSB.
    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

    typedef enum logic [CONDSIZE-1:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_ADC = 4'd1,
        ALU_SUB = 4'd2,
        ALU_SBC = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6,
        ALU_NOT = 4'd7,
        ALU_SHL = 4'd8,
        ALU_SHR = 4'd9,
        ALU_ASR = 4'd10,
        ALU_CMP = 4'd11,
        ALU_TST = 4'd12,
        ALU_MOV = 4'd13,
        ALU_INC = 4'd14,
        ALU_DEC = 4'd15
    } alu_op_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    function automatic flags_t unpack_flags(input logic [NUMFLAGS-1:0] raw);
        flags_t f;
        f.c = raw[FLAG_C];
        f.v = raw[FLAG_V];
        f.z = raw[FLAG_Z];
        f.n = raw[FLAG_N];
        return f;
    endfunction

endpackage

// File: rtl/cond_branch_unit_cond_eval.sv
// Combinational condition evaluator: decides whether a condition code holds
// for a given {C V Z N} flag vector.
module cond_eval
    import cond_branch_unit_pkg::*;
#(
    parameter int numflags = NUMFLAGS,
    parameter int condsize = CONDSIZE
) (
    input  logic [numflags-1:0] flags,
    input  logic [condsize-1:0] cond,
    output logic                cond_true
);

    flags_t f;
    logic   n_eq_v;

    assign f      = unpack_flags(flags);
    assign n_eq_v = (f.n == f.v);

    always_comb begin
        // NOTE: the output gets a value before the case so no path can leave it
        // unassigned; an unassigned path in always_comb infers a latch.
        cond_true = 1'b0;
        unique case (cond_e'(cond))
            COND_EQ: cond_true = f.z;
            COND_NE: cond_true = !f.z;
            COND_CS: cond_true = f.c;
            COND_CC: cond_true = !f.c;
            COND_MI: cond_true = f.n;
            COND_PL: cond_true = !f.n;
            COND_VS: cond_true = f.v;
            COND_VC: cond_true = !f.v;
            COND_HI: cond_true = f.c && !f.z;
            COND_LS: cond_true = !f.c || f.z;
            COND_GE: cond_true = n_eq_v;
            COND_LT: cond_true = !n_eq_v;
            COND_GT: cond_true = !f.z && n_eq_v;
            COND_LE: cond_true = f.z || !n_eq_v;
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_branch_unit.sv
// Conditional branch unit: holds the PC and flag register, resolves branch
// conditions with same-cycle flag forwarding, and inserts one flush cycle per taken branch.
module cond_branch_unit
    import cond_branch_unit_pkg::*;
#(
    parameter int aluwidth = ALUWIDTH,
    parameter int numflags = NUMFLAGS,
    parameter int condsize = CONDSIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [numflags-1:0] flags_in,
    input  logic                flags_we,
    input  logic                br_valid,
    input  logic [condsize-1:0] cond,
    input  logic [aluwidth-1:0] br_offset,
    input  logic                pc_en,
    output logic [aluwidth-1:0] pc,
    output logic [numflags-1:0] flags_q,
    output logic                taken,
    output logic                flush
);

    state_e                state_q, state_d;
    logic [aluwidth-1:0]   pc_q, pc_d;
    logic [numflags-1:0]   flags_d;
    logic                  taken_q, taken_d;
    logic [numflags-1:0]   eff_flags;
    logic                  cond_true;

    // A flag write in the same cycle as the branch must steer that branch.
    assign eff_flags = flags_we ? flags_in : flags_q;

    cond_eval #(
        .numflags (numflags),
        .condsize (condsize)
    ) u_cond_eval (
        .flags     (eff_flags),
        .cond      (cond),
        .cond_true (cond_true)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        taken_d = taken_q;
        flags_d = flags_q;

        if (pc_en) begin
            if (flags_we) begin
                flags_d = flags_in;
            end

            unique case (state_q)
                ST_RUN: begin
                    if (br_valid && cond_true) begin
                        pc_d    = pc_q + br_offset;
                        taken_d = 1'b1;
                        state_d = ST_FLUSH;
                    end else begin
                        pc_d    = pc_q + aluwidth'(1);
                        taken_d = 1'b0;
                    end
                end
                // The slot behind a taken branch is discarded; the PC already
                // points at the target.
                ST_FLUSH: begin
                    taken_d = 1'b0;
                    state_d = ST_RUN;
                end
                default: begin
                    taken_d = 1'b0;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
            flags_q <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flags_q <= flags_d;
            taken_q <= taken_d;
        end
    end

    assign pc    = pc_q;
    assign taken = taken_q;
    assign flush = (state_q == ST_FLUSH);

endmodule
